// File: rtl/tx_pkg.sv
// tx_pkg: shared states, parity codes and sizing helpers for the serial transmitter
package tx_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} txState_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    function automatic int frame_bits(input int dataBits, input int parity);
        return dataBits + ((parity != PAR_NONE) ? 3 : 2);
    endfunction

    function automatic int cnt_width(input int clksPerBit);
        return $clog2(clksPerBit);
    endfunction

endpackage

// File: rtl/tx_baud_tick.sv
// tx_baud_tick: modulo-CLKS_PER_BIT counter that flags the last cycle of each bit period
module tx_baud_tick
    import tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic strobe
);

    localparam int CW = cnt_width(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count;

    assign strobe = en && (count == LAST);

    // Count cycles of the current bit; wrap at the strobe, hold at zero while cleared
    always_ff @(posedge clk or posedge rst) begin
        if (rst) count <= '0;
        else count <= (clr || strobe) ? '0 : en ? count + 1'b1 : count;
    end

endmodule

// File: rtl/tx_frame_serializer.sv
// tx_frame_serializer: async serial framer (start, LSB-first data, optional parity, stop)
module tx_frame_serializer
    import tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = PAR_NONE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_en,
    input  logic [DATA_BITS-1:0] char_data,
    input  logic                 char_valid,
    output logic                 char_ready,
    output logic                 tx_line,
    output logic                 bit_strobe,
    output logic                 busy,
    output logic                 char_sent
);

    localparam int FB = frame_bits(DATA_BITS, PARITY);
    localparam int IW = $clog2(FB);
    localparam logic [IW-1:0] LAST_IDX = IW'(FB - 1);

    // The start bit is driven straight onto tx_line at accept, so the shifter holds the rest
    txState_t      state, nextState;
    logic [FB-2:0] shiftReg, frameWord;
    logic [IW-1:0] bitIdx;
    logic          accept, lastBit, abort, par;

    assign char_ready = (state == IDLE || state == DONE) && tx_en;
    assign accept     = char_valid && char_ready;
    assign abort      = (state == SHIFT) && !tx_en;
    assign lastBit    = bit_strobe && (bitIdx == LAST_IDX);
    assign par        = (PARITY == PAR_ODD) ? ~^char_data : ^char_data;

    tx_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) baudTick (
        .clk(clk),
        .rst(rst),
        .clr(state != SHIFT || !tx_en),
        .en(state == SHIFT),
        .strobe(bit_strobe)
    );

    // Build the post-start portion of the frame: data, optional parity, stop
    always_comb begin
        frameWord = '1;
        frameWord[DATA_BITS-1:0] = char_data;
        if (PARITY != PAR_NONE) frameWord[DATA_BITS] = par;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= nextState;
    end

    // Next state and status outputs
    always_comb begin
        nextState = (state == SHIFT) ? (!tx_en ? IDLE : lastBit ? DONE : SHIFT)
                                     : (accept ? SHIFT : IDLE);
        busy      = (state == SHIFT);
        char_sent = (state == DONE);
    end

    // Shifter, bit index and registered line driver
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shiftReg <= '0;
            bitIdx   <= '0;
            tx_line  <= 1'b1;
        end else if (accept) begin
            shiftReg <= frameWord;
            bitIdx   <= '0;
            tx_line  <= 1'b0;
        end else if (abort) begin
            shiftReg <= '0;
            bitIdx   <= '0;
            tx_line  <= 1'b1;
        end else if (bit_strobe) begin
            shiftReg <= {1'b1, shiftReg[FB-2:1]};
            bitIdx   <= bitIdx + 1'b1;
            tx_line  <= lastBit | shiftReg[0];
        end
    end

endmodule

// File: tb/tb_tx_frame_serializer.sv
// tb_tx_frame_serializer: directed checks of framing, parity, back-to-back, abort and reset
module tb_tx_frame_serializer;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       txEn = 1'b1;
    logic [7:0] charData = 8'h00;
    logic       charValid = 1'b0;
    logic       charReady[3];
    logic       txLine[3];
    logic       bitStrobe[3];
    logic       busy[3];
    logic       charSent[3];
    int         testCount = 0;
    int         errCount = 0;

    always #5 clk = ~clk;

    // Unit g runs with PARITY = g (none, even, odd); all share the same stimulus
    for (genvar g = 0; g < 3; g++) begin : gDut
        tx_frame_serializer #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(g)) dut (
            .clk(clk),
            .rst(rst),
            .tx_en(txEn),
            .char_data(charData),
            .char_valid(charValid),
            .char_ready(charReady[g]),
            .tx_line(txLine[g]),
            .bit_strobe(bitStrobe[g]),
            .busy(busy[g]),
            .char_sent(charSent[g])
        );
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testCount++;
        if (got !== exp) begin
            errCount++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        charValid = 1'b0;
        repeat (n) tick();
    endtask

    // Caller raises charValid in cycle 0; this follows cycles 1..fb*CPB+1 of unit u
    task automatic watchFrame(input string tag, input int u, input int fb,
                              input logic [15:0] expFrame, input logic dropValid,
                              input logic [7:0] nextData);
        int bad = 0;
        int busyBad = 0;
        int strobes = 0;
        int sentCnt = 0;
        int sentAt = -1;
        for (int c = 1; c <= fb * CPB + 1; c++) begin
            tick();
            if (c == 1) begin
                if (dropValid) charValid = 1'b0;
                else charData = nextData;
            end
            if (c <= fb * CPB) begin
                if (txLine[u] !== expFrame[(c - 1) / CPB]) bad++;
                if (busy[u] !== 1'b1) busyBad++;
            end else if (busy[u] !== 1'b0 || txLine[u] !== 1'b1) busyBad++;
            if (bitStrobe[u]) strobes++;
            if (charSent[u]) begin
                sentCnt++;
                sentAt = c;
            end
        end
        checkVal({tag, ".bits"}, bad, 0);
        checkVal({tag, ".busy"}, busyBad, 0);
        checkVal({tag, ".strobes"}, strobes, fb);
        checkVal({tag, ".sentCnt"}, sentCnt, 1);
        checkVal({tag, ".sentAt"}, sentAt, fb * CPB + 1);
    endtask

    initial begin
        int bad;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        checkVal("reset.line", txLine[0], 1);
        checkVal("reset.busy", busy[0], 0);
        checkVal("reset.sent", charSent[0], 0);
        checkVal("reset.strobe", bitStrobe[0], 0);
        checkVal("reset.ready", charReady[0], 1);

        // Plain 8N1 frame of 'A'
        charData = 8'h41;
        charValid = 1'b1;
        watchFrame("plain41", 0, 10, 16'h0282, 1'b1, 8'h00);

        // Even then odd parity on 'A'
        idle(6);
        charValid = 1'b1;
        watchFrame("even41", 1, 11, 16'h0482, 1'b1, 8'h00);
        idle(4);
        charValid = 1'b1;
        watchFrame("odd41", 2, 11, 16'h0682, 1'b1, 8'h00);

        // Back-to-back: second accept lands in the DONE cycle
        idle(6);
        charData = 8'h55;
        charValid = 1'b1;
        watchFrame("b2b55", 0, 10, 16'h02AA, 1'b0, 8'hAA);
        checkVal("b2b.readyInDone", charReady[0], 1);
        watchFrame("b2bAA", 0, 10, 16'h0354, 1'b1, 8'h00);

        // Abort by dropping tx_en mid-frame
        idle(6);
        charData = 8'h7E;
        charValid = 1'b1;
        tick();
        charValid = 1'b0;
        repeat (14) tick();
        checkVal("abort.busyBefore", busy[0], 1);
        txEn = 1'b0;
        tick();
        checkVal("abort.line", txLine[0], 1);
        checkVal("abort.busy", busy[0], 0);
        checkVal("abort.ready", charReady[0], 0);
        bad = 0;
        repeat (30) begin
            tick();
            if (charSent[0] || busy[0] || txLine[0] !== 1'b1) bad++;
        end
        checkVal("abort.quiet", bad, 0);
        txEn = 1'b1;
        #1;
        checkVal("abort.readyAgain", charReady[0], 1);
        charValid = 1'b1;
        watchFrame("resend7E", 0, 10, 16'h02FC, 1'b1, 8'h00);

        // Asynchronous reset in the middle of a data bit
        idle(6);
        charData = 8'h00;
        charValid = 1'b1;
        tick();
        charValid = 1'b0;
        repeat (9) tick();
        checkVal("rst.lineLowBefore", txLine[0], 0);
        checkVal("rst.busyBefore", busy[0], 1);
        #2 rst = 1'b1;
        #1;
        checkVal("rst.lineAsync", txLine[0], 1);
        checkVal("rst.busyAsync", busy[0], 0);
        tick();
        rst = 1'b0;
        repeat (2) tick();
        checkVal("rst.readyAfter", charReady[0], 1);
        charValid = 1'b1;
        watchFrame("afterRst00", 0, 10, 16'h0200, 1'b1, 8'h00);

        // Disabled transmitter ignores a pending character
        idle(6);
        txEn = 1'b0;
        charData = 8'h33;
        charValid = 1'b1;
        bad = 0;
        repeat (50) begin
            tick();
            if (charReady[0] || busy[0] || charSent[0] || txLine[0] !== 1'b1) bad++;
        end
        checkVal("disabled.quiet", bad, 0);
        checkVal("disabled.ready", charReady[0], 0);

        $display("[TB] %0d tests run, %0d failed", testCount, errCount);
        $finish;
    end

endmodule
